// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared clock constants, buzzer source codes and scheduler states
package clock_pkg;

    // 100 ms cadence tick at the 50 MHz board clock
    localparam int DEFAULT_TICK_CNT = 5000000;
    localparam int MAX_CHIME        = 12;

    typedef enum logic [5:0] {
        ST_IDLE      = 6'b000001,
        ST_CLICK     = 6'b000010,
        ST_CHIME_ON  = 6'b000100,
        ST_CHIME_OFF = 6'b001000,
        ST_ALARM_ON  = 6'b010000,
        ST_ALARM_OFF = 6'b100000
    } beep_state_e;

    localparam logic [1:0] SRC_NONE  = 2'd0;
    localparam logic [1:0] SRC_CLICK = 2'd1;
    localparam logic [1:0] SRC_CHIME = 2'd2;
    localparam logic [1:0] SRC_ALARM = 2'd3;

    function automatic logic [3:0] chime_beeps(input logic [3:0] num);
        return (num > 4'(MAX_CHIME)) ? 4'(MAX_CHIME) : num;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - wrapping prescaler with synchronous clear and terminal-count tick
module tick_gen
    import clock_pkg::*;
#(
    parameter int TICK_CNT = DEFAULT_TICK_CNT
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int CW = (TICK_CNT > 1) ? $clog2(TICK_CNT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_CNT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // tick comes from the registered count only, so clr_i may depend on it
    assign tick_o = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr_i || tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/beep_scheduler.sv
// rtl/beep_scheduler.sv - buzzer owner arbitrating alarm, hourly chime and key click cadences
module beep_scheduler
    import clock_pkg::*;
#(
    parameter int TICK_CNT        = DEFAULT_TICK_CNT,
    parameter int CLICK_TICKS     = 1,
    parameter int CHIME_ON_TICKS  = 2,
    parameter int CHIME_OFF_TICKS = 2,
    parameter int ALARM_ON_TICKS  = 5,
    parameter int ALARM_OFF_TICKS = 5
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       alarm_req,
    input  logic       chime_req,
    input  logic [3:0] chime_num,
    input  logic       click_req,
    input  logic       mute,
    output logic       beep_out,
    output logic       busy,
    output logic [1:0] src
);

    localparam int PH_W = 8;
    localparam logic [PH_W-1:0] CLICK_LAST     = PH_W'(CLICK_TICKS - 1);
    localparam logic [PH_W-1:0] CHIME_ON_LAST  = PH_W'(CHIME_ON_TICKS - 1);
    localparam logic [PH_W-1:0] CHIME_OFF_LAST = PH_W'(CHIME_OFF_TICKS - 1);
    localparam logic [PH_W-1:0] ALARM_ON_LAST  = PH_W'(ALARM_ON_TICKS - 1);
    localparam logic [PH_W-1:0] ALARM_OFF_LAST = PH_W'(ALARM_OFF_TICKS - 1);

    beep_state_e     state_q, state_d;
    logic [PH_W-1:0] phase_q, phase_d;
    logic [3:0]      beeps_q, beeps_d;
    logic            tick;
    logic            presc_clr;
    logic            chime_go;
    logic            in_alarm;

    assign chime_go  = chime_req && (chime_num != 4'd0);
    assign in_alarm  = (state_q == ST_ALARM_ON) || (state_q == ST_ALARM_OFF);
    assign presc_clr = (state_d != state_q) || (state_q == ST_IDLE);

    tick_gen #(
        .TICK_CNT (TICK_CNT)
    ) u_tick_gen (
        .clk_i  (sys_clk),
        .rst_i  (rst),
        .clr_i  (presc_clr),
        .tick_o (tick)
    );

    always_comb begin
        state_d = state_q;
        beeps_d = beeps_q;
        if (alarm_req) begin
            // alarm preempts anything else; an interrupted chime is forgotten
            if (!in_alarm) begin
                state_d = ST_ALARM_ON;
                beeps_d = 4'd0;
            end else if (tick && state_q == ST_ALARM_ON && phase_q == ALARM_ON_LAST) begin
                state_d = ST_ALARM_OFF;
            end else if (tick && state_q == ST_ALARM_OFF && phase_q == ALARM_OFF_LAST) begin
                state_d = ST_ALARM_ON;
            end
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (chime_go) begin
                        state_d = ST_CHIME_ON;
                        beeps_d = chime_beeps(chime_num);
                    end else if (click_req) begin
                        state_d = ST_CLICK;
                    end
                end
                ST_CLICK: begin
                    if (chime_go) begin
                        state_d = ST_CHIME_ON;
                        beeps_d = chime_beeps(chime_num);
                    end else if (tick && phase_q == CLICK_LAST) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_CHIME_ON: begin
                    if (tick && phase_q == CHIME_ON_LAST) begin
                        state_d = ST_CHIME_OFF;
                        beeps_d = beeps_q - 4'd1;
                    end
                end
                ST_CHIME_OFF: begin
                    if (tick && phase_q == CHIME_OFF_LAST) begin
                        state_d = (beeps_q == 4'd0) ? ST_IDLE : ST_CHIME_ON;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    beeps_d = 4'd0;
                end
            endcase
        end
    end

    always_comb begin
        phase_d = phase_q;
        if (state_d != state_q) begin
            phase_d = '0;
        end else if (tick) begin
            phase_d = phase_q + 1'b1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            phase_q  <= '0;
            beeps_q  <= 4'd0;
            beep_out <= 1'b0;
            busy     <= 1'b0;
            src      <= SRC_NONE;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            beeps_q  <= beeps_d;
            beep_out <= ((state_q == ST_CLICK) || (state_q == ST_CHIME_ON) ||
                         (state_q == ST_ALARM_ON)) && !mute;
            busy     <= (state_q != ST_IDLE);
            case (state_q)
                ST_CLICK:                   src <= SRC_CLICK;
                ST_CHIME_ON, ST_CHIME_OFF:  src <= SRC_CHIME;
                ST_ALARM_ON, ST_ALARM_OFF:  src <= SRC_ALARM;
                default:                    src <= SRC_NONE;
            endcase
        end
    end

endmodule

// File: tb/tb_beep_scheduler.sv
// tb/tb_beep_scheduler.sv - directed self-checking bench for beep_scheduler
module tb_beep_scheduler;

    logic       sys_clk = 1'b0;
    logic       rst = 1'b1;
    logic       alarm_req = 1'b0;
    logic       chime_req = 1'b0;
    logic [3:0] chime_num = 4'd0;
    logic       click_req = 1'b0;
    logic       mute = 1'b0;
    logic       beep_out;
    logic       busy;
    logic [1:0] src;

    int n_tests = 0;
    int n_fail  = 0;
    int highs, rises, busy_n, src_bad, bad;

    always #5 sys_clk = ~sys_clk;

    beep_scheduler #(
        .TICK_CNT (4)
    ) dut (
        .sys_clk   (sys_clk),
        .rst       (rst),
        .alarm_req (alarm_req),
        .chime_req (chime_req),
        .chime_num (chime_num),
        .click_req (click_req),
        .mute      (mute),
        .beep_out  (beep_out),
        .busy      (busy),
        .src       (src)
    );

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic cyc(input int n);
        repeat (n) step();
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // steps until busy has risen and fallen again (or max_cyc expires)
    task automatic run_seq(input int max_cyc, input logic [1:0] exp_src,
                           output int hi, output int ri, output int bn, output int sb);
        logic prev;
        bit   seen;
        hi = 0; ri = 0; bn = 0; sb = 0; seen = 0;
        prev = beep_out;
        for (int i = 0; i < max_cyc; i++) begin
            step();
            if (beep_out && !prev) ri++;
            if (beep_out) hi++;
            prev = beep_out;
            if (busy) begin
                bn++;
                seen = 1;
                if (src !== exp_src) sb++;
            end else if (seen) begin
                break;
            end
        end
    endtask

    initial begin
        // reset
        cyc(2);
        chk("rst_beep", int'(beep_out), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_src", int'(src), 0);
        rst = 1'b0;
        step();
        chk("idle_busy", int'(busy), 0);

        // key click
        click_req = 1'b1; step(); click_req = 1'b0;
        chk("click_lat_beep", int'(beep_out), 0);
        step();
        chk("click_beep_on", int'(beep_out), 1);
        chk("click_busy", int'(busy), 1);
        chk("click_src", int'(src), 1);
        cyc(3);
        chk("click_beep_last", int'(beep_out), 1);
        step();
        chk("click_beep_off", int'(beep_out), 0);
        chk("click_busy_off", int'(busy), 0);
        chk("click_src_off", int'(src), 0);

        // chime of 3
        chime_num = 4'd3; chime_req = 1'b1; step(); chime_req = 1'b0;
        run_seq(200, 2'd2, highs, rises, busy_n, src_bad);
        chk("chime3_highs", highs, 24);
        chk("chime3_beeps", rises, 3);
        chk("chime3_busy", busy_n, 48);
        chk("chime3_src", src_bad, 0);

        // chime of 0 is ignored
        chime_num = 4'd0; chime_req = 1'b1; step(); chime_req = 1'b0;
        run_seq(20, 2'd2, highs, rises, busy_n, src_bad);
        chk("chime0_busy", busy_n, 0);

        // chime of 15 clamps to 12
        chime_num = 4'd15; chime_req = 1'b1; step(); chime_req = 1'b0;
        run_seq(300, 2'd2, highs, rises, busy_n, src_bad);
        chk("chime15_beeps", rises, 12);
        chk("chime15_highs", highs, 96);
        chk("chime15_busy", busy_n, 192);

        // alarm cadence 20 on / 20 off
        alarm_req = 1'b1; step();
        bad = 0;
        for (int k = 1; k <= 90; k++) begin
            step();
            if (beep_out !== (((k - 1) / 20) % 2 == 0)) bad++;
            if (src !== 2'd3) bad++;
        end
        chk("alarm_cadence", bad, 0);
        alarm_req = 1'b0;
        step();
        chk("alarm_fall_beep1", int'(beep_out), 1);
        chk("alarm_fall_busy1", int'(busy), 1);
        step();
        chk("alarm_fall_beep2", int'(beep_out), 0);
        chk("alarm_fall_busy2", int'(busy), 0);
        chk("alarm_fall_src", int'(src), 0);

        // preemption of a chime(5) during its second beep
        chime_num = 4'd5; chime_req = 1'b1; step(); chime_req = 1'b0;
        cyc(20);
        chk("pre_beep2_on", int'(beep_out), 1);
        alarm_req = 1'b1; step();
        chk("pre_src_old", int'(src), 2);
        step();
        chk("pre_src_alarm", int'(src), 3);
        chk("pre_beep_alarm", int'(beep_out), 1);
        cyc(3);
        alarm_req = 1'b0;
        cyc(2);
        chk("pre_idle", int'(busy), 0);
        run_seq(40, 2'd2, highs, rises, busy_n, src_bad);
        chk("pre_no_resume", busy_n, 0);

        // chime and click together: chime wins
        chime_num = 4'd2; chime_req = 1'b1; click_req = 1'b1; step();
        chime_req = 1'b0; click_req = 1'b0;
        run_seq(200, 2'd2, highs, rises, busy_n, src_bad);
        chk("coll_beeps", rises, 2);
        chk("coll_busy", busy_n, 32);
        chk("coll_src", src_bad, 0);

        // click during chime is dropped
        chime_num = 4'd1; chime_req = 1'b1; step(); chime_req = 1'b0;
        cyc(4);
        click_req = 1'b1; step(); click_req = 1'b0;
        run_seq(100, 2'd2, highs, rises, busy_n, src_bad);
        chk("clk_in_chime_busy", busy_n, 11);
        chk("clk_in_chime_highs", highs, 3);
        chk("clk_in_chime_src", src_bad, 0);
        cyc(8);
        chk("clk_in_chime_idle", int'(busy), 0);

        // chime during click preempts it
        click_req = 1'b1; step(); click_req = 1'b0;
        step();
        chk("cic_src_click", int'(src), 1);
        chime_num = 4'd1; chime_req = 1'b1; step(); chime_req = 1'b0;
        chk("cic_src_pending", int'(src), 1);
        step();
        chk("cic_src_chime", int'(src), 2);
        chk("cic_beep", int'(beep_out), 1);
        run_seq(100, 2'd2, highs, rises, busy_n, src_bad);
        chk("cic_busy", busy_n, 15);
        chk("cic_highs", highs, 7);

        // mute during alarm keeps cadence running
        alarm_req = 1'b1; mute = 1'b1; step();
        step();
        chk("mute_beep", int'(beep_out), 0);
        chk("mute_src", int'(src), 3);
        cyc(29);
        mute = 1'b0;
        cyc(5);
        chk("unmute_off_phase", int'(beep_out), 0);
        cyc(5);
        chk("unmute_off_end", int'(beep_out), 0);
        step();
        chk("unmute_on_phase", int'(beep_out), 1);
        alarm_req = 1'b0;
        cyc(2);
        chk("mute_alarm_idle", int'(busy), 0);

        // reset mid-chime, requests during reset ignored
        chime_num = 4'd3; chime_req = 1'b1; step(); chime_req = 1'b0;
        cyc(10);
        rst = 1'b1; click_req = 1'b1; step();
        chk("rst_mid_beep", int'(beep_out), 0);
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_src", int'(src), 0);
        rst = 1'b0; click_req = 1'b0;
        run_seq(40, 2'd2, highs, rises, busy_n, src_bad);
        chk("rst_no_resume", busy_n, 0);
        chk("rst_no_sound", highs, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
